ula_arbiter: RTL

ULA_ARBITER -- requirements
Module: ula_arbiter

---
 rtl/ula_pkg.sv | 27 ++
 rtl/rr_arbiter2.sv | 33 +++
 rtl/ula_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the ULA arbiter: ALU op codes, the highest legal
// op code, the arbiter FSM state encoding and a legality helper.
package ula_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;

    // Codes above this value are rejected without touching the ALU.
    localparam logic [2:0] OP_MAX_LEGAL = OP_SLT;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } ula_state_t;

    // Op code legality; callers widen their op code to 32 bits so the
    // helper works for any OP_W.
    function automatic logic op_legal(input logic [31:0] op);
        return op <= 32'(OP_MAX_LEGAL);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Grant is combinational and one-hot (or zero
// when nobody requests); the tie-break pointer moves only on advance.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // High when requester 1 wins a tie; after reset requester 0 wins.
    logic prio1;

    // Pick the single requester, or on a tie the one holding priority.
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = prio1 ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

    // After a served grant, priority goes to the other requester.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prio1 <= 1'b0;
        end else if (advance) begin
            prio1 <= grant[0];
        end
    end

endmodule

// File: rtl/ula_arbiter.sv
// Shares one registered ALU between two requesters. A granted operation is
// latched onto the ula_* outputs, the ALU result is captured two cycles
// later and returned on the owning requester's response channel.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. Requesters hold valid and payload until ready; the block
// holds rspN_valid and the response payload until rspN_ready is sampled high.
module ula_arbiter
    import ula_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OP_W   = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic [DATA_W-1:0] ula_entrada1,
    output logic [DATA_W-1:0] ula_entrada2,
    output logic [OP_W-1:0]   ula_ALUControl,
    input  logic [DATA_W-1:0] ula_resultado,
    input  logic              ula_zero,
    output logic [1:0]        dbg_state
);

    ula_state_t        state;
    logic              owner_id;
    logic [1:0]        grant;
    logic              in_idle;
    logic              accept;
    logic              sel_id;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [OP_W-1:0]   sel_op;
    logic              sel_legal;
    logic              rsp_done;

    rr_arbiter2 u_rr (
        .clock   (clock),
        .reset   (reset),
        .req     ({req1_valid, req0_valid}),
        .advance (accept),
        .grant   (grant)
    );

    // Ready only in IDLE and only for the granted requester; held low while
    // reset is asserted so nothing can be accepted during it.
    assign in_idle    = (state == ST_IDLE) && !reset;
    assign req0_ready = in_idle && grant[0];
    assign req1_ready = in_idle && grant[1];
    assign accept     = req0_ready || req1_ready;

    assign sel_id    = grant[1];
    assign sel_a     = sel_id ? req1_a  : req0_a;
    assign sel_b     = sel_id ? req1_b  : req0_b;
    assign sel_op    = sel_id ? req1_op : req0_op;
    assign sel_legal = op_legal(32'(sel_op));

    // Only the owner's rsp_ready ends the response; the other one is ignored.
    assign rsp_done = (state == ST_RESP) && (owner_id ? rsp1_ready : rsp0_ready);

    assign dbg_state = state;

    // Transaction FSM: accept -> ISSUE -> CAPTURE -> RESP, or straight to
    // RESP with an error for an unsupported op code.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            owner_id       <= 1'b0;
            rsp0_valid     <= 1'b0;
            rsp1_valid     <= 1'b0;
            rsp_result     <= '0;
            rsp_zero       <= 1'b0;
            rsp_err        <= 1'b0;
            ula_entrada1   <= '0;
            ula_entrada2   <= '0;
            ula_ALUControl <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        owner_id <= sel_id;
                        if (sel_legal) begin
                            // The ALU only ever sees legal operations.
                            ula_entrada1   <= sel_a;
                            ula_entrada2   <= sel_b;
                            ula_ALUControl <= sel_op;
                            state          <= ST_ISSUE;
                        end else begin
                            rsp_result <= '0;
                            rsp_zero   <= 1'b0;
                            rsp_err    <= 1'b1;
                            rsp0_valid <= !sel_id;
                            rsp1_valid <= sel_id;
                            state      <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE: begin
                    // ALU registers its inputs on this edge.
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    rsp_result <= ula_resultado;
                    rsp_zero   <= ula_zero;
                    rsp_err    <= 1'b0;
                    rsp0_valid <= !owner_id;
                    rsp1_valid <= owner_id;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_done) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
